fetch_queue_unit: RTL and testbench
===================================

# fetch_queue_unit

Parametrised instruction fetch front end with a decoupling instruction queue. It issues FETCH_W-wide requests to a synchronous instruction memory and buffers returned instructions, each tagged with its PC, in a QUEUE_DEPTH-entry circular queue. It presents up to FETCH_W in-order instructions per cycle to decode. Branch redirects flush the queue and squash any in-flight response. The block sits between instruction memory and the decode stage.

## Interface
- INSTR_W, 16, instruction width in bits
- ADDR_W, 16, PC width in bits; PC counts instructions, not bytes
- FETCH_W, 2, instructions per memory request and maximum instructions presented to decode (1..4)
- QUEUE_DEPTH, 8, number of queue entries; power of two, at least 2*FETCH_W
- RESET_PC, 0, fetch PC after reset
- clk  in  1  the block's single clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  memory read request this cycle
- imem_req_addr  out  ADDR_W  PC of the first instruction requested
- imem_rsp_data  in  FETCH_W*INSTR_W  data returned exactly one cycle after the request; word i is at bits [i*INSTR_W +: INSTR_W] and holds the instruction at addr+i
- redirect_valid  in  1  branch taken; flush the block and refetch from redirect_pc
- redirect_pc  in  ADDR_W  redirect target
- stall  in  1  decode stall; no dequeue this cycle
- deq_count  in  $clog2(FETCH_W+1)  number of head instructions decode consumes this cycle
- out_instr  out  FETCH_W*INSTR_W  slot i holds queue entry head+i, or 0 (NOP) when that slot is not valid
- out_pc  out  FETCH_W*ADDR_W  PC of each slot, or 0 when that slot is not valid
- out_valid  out  FETCH_W  thermometer code; bit i is 1 iff count > i
- queue_count  out  $clog2(QUEUE_DEPTH+1)  number of occupied entries

## Operation
- State:
  - fetch_pc
  - inflight flag and inflight_addr
  - queue storage holding instruction and PC per entry
  - head and tail pointers
  - count
- Request rule: imem_req_valid = !redirect_valid && (QUEUE_DEPTH - count) >= FETCH_W*(1 + inflight).
  - The rule uses the current count and is deliberately conservative, so a response always has room.
  - imem_req_addr = fetch_pc.
  - On a request: fetch_pc <= fetch_pc + FETCH_W, which wraps modulo 2^ADDR_W. inflight <= 1 and inflight_addr <= fetch_pc. Otherwise inflight <= 0.
- Response: in the cycle after a request, FETCH_W entries are written at tail with instructions from imem_rsp_data and PCs inflight_addr+i (modulo 2^ADDR_W). tail and count advance by FETCH_W.
- Dequeue: pop = stall ? 0 : min(deq_count, count).
  - deq_count values above count are clipped, never an error.
  - head advances by pop.
- Simultaneous push and pop are both applied: count_next = count - pop + push.
- Overflow is impossible by construction. The bench asserts count never exceeds QUEUE_DEPTH.
- Redirect has the highest priority over stall, dequeue, enqueue and request:
  - head, tail and count are cleared to 0.
  - A response arriving in the redirect cycle is discarded.
  - inflight <= 0.
  - fetch_pc <= redirect_pc.
  - No request is made in the redirect cycle.
- Outputs: out_instr, out_pc and out_valid are combinational from the queue registers, head and count. out_instr is never driven from imem_rsp_data directly.
- Pointers wrap modulo QUEUE_DEPTH.

## Timing
- Reset (reset_n low), applying asynchronously even mid-operation:
  - fetch_pc=RESET_PC, count=0, head=tail=0, inflight=0.
  - imem_req_valid=0 while reset_n is low.
  - out_valid=0, out_instr=0, out_pc=0, queue_count=0.
  - Any in-flight response is dropped.
- In the first cycle after reset_n rises, imem_req_valid=1 with addr=RESET_PC.
- Latency: request in cycle t, enqueue at the end of t+1, out_valid visible in t+2.
- Redirect in cycle t: request for redirect_pc in t+1, instructions visible in t+3.
- Throughput: back-to-back requests are sustained while free space >= 2*FETCH_W. This gives FETCH_W instructions per cycle with continuous draining.
- Queue full or nearly full: requests stop. They resume in the cycle after free space again satisfies the request rule.

## Test plan
- Reset and startup, defaults, decode draining deq_count=2 every cycle -> requests at addresses 0, 2, 4, …; in cycle 2 out_pc={1,0} and out_valid=2'b11, then continuous PCs with no gaps.
- Fill under stall: stall=1 from reset -> queue_count reaches 8, then imem_req_valid stays 0 and count holds 8. Release stall with deq_count=2 -> PCs 0..7 are presented in order, and fetching resumes with no duplicated or lost PC.
- Redirect with a response in flight, redirect_pc=0x0040 one cycle after a request to 0x0006 -> response for 0x0006 is discarded and queue_count=0; the next request is to 0x0040, and out_pc slot 0 = 0x0040 two cycles later.
- Simultaneous redirect, dequeue and response: stall=0, deq_count=2, redirect_valid=1 -> queue empties and pop is ignored; count=0 the next cycle.
- Clip and partial issue, count=1 and deq_count=2 -> out_valid=2'b01, slot 1 shows out_instr=0 and out_pc=0, one entry pops, count goes to 0 with no underflow.
- PC wrap, redirect_pc=0xFFFE -> entries show PCs 0xFFFE, 0xFFFF, then 0x0000, 0x0001; the second request address is 0x0000.

Source files
------------

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: issues FETCH_W-wide memory reads and buffers the
// returned instructions with their PCs in a circular queue feeding decode.
module fetch_queue_unit #(
    parameter int INSTR_W     = 16,
    parameter int ADDR_W      = 16,
    parameter int FETCH_W     = 2,
    parameter int QUEUE_DEPTH = 8,
    parameter int RESET_PC    = 0
) (
    input  logic                               clk,
    input  logic                               reset_n,
    output logic                               imem_req_valid,
    output logic [ADDR_W-1:0]                  imem_req_addr,
    input  logic [FETCH_W*INSTR_W-1:0]         imem_rsp_data,
    input  logic                               redirect_valid,
    input  logic [ADDR_W-1:0]                  redirect_pc,
    input  logic                               stall,
    input  logic [$clog2(FETCH_W+1)-1:0]       deq_count,
    output logic [FETCH_W*INSTR_W-1:0]         out_instr,
    output logic [FETCH_W*ADDR_W-1:0]          out_pc,
    output logic [FETCH_W-1:0]                 out_valid,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);

    logic [ADDR_W-1:0]  fetch_pc_r;
    logic               inflight_r;
    logic [ADDR_W-1:0]  inflight_addr_r;
    logic [INSTR_W-1:0] instr_mem_r [QUEUE_DEPTH];
    logic [ADDR_W-1:0]  pc_mem_r    [QUEUE_DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [CNT_W-1:0]   count_r;

    logic [CNT_W-1:0]   free_s;
    logic [CNT_W-1:0]   need_s;
    logic [CNT_W-1:0]   deq_ext_s;
    logic [CNT_W-1:0]   pop_s;
    logic [CNT_W-1:0]   push_s;
    logic               req_s;
    logic [PTR_W-1:0]   rd_idx_s;

    // Request decision and push/pop amounts for this cycle
    always_comb begin
        free_s    = CNT_W'(QUEUE_DEPTH) - count_r;
        deq_ext_s = CNT_W'(deq_count);
        // Reserve room for a response already in flight so a new one always fits
        if (inflight_r) begin
            need_s = CNT_W'(2 * FETCH_W);
            push_s = CNT_W'(FETCH_W);
        end else begin
            need_s = CNT_W'(FETCH_W);
            push_s = {CNT_W{1'b0}};
        end
        req_s = reset_n && !redirect_valid && (free_s >= need_s);
        if (stall) begin
            pop_s = {CNT_W{1'b0}};
        end else if (deq_ext_s < count_r) begin
            pop_s = deq_ext_s;
        end else begin
            pop_s = count_r;
        end
    end

    // Decode-facing view of the head entries, zeroed beyond the occupied count
    always_comb begin
        out_instr = {(FETCH_W*INSTR_W){1'b0}};
        out_pc    = {(FETCH_W*ADDR_W){1'b0}};
        out_valid = {FETCH_W{1'b0}};
        rd_idx_s  = {PTR_W{1'b0}};
        for (int i = 0; i < FETCH_W; i++) begin
            rd_idx_s = head_r + PTR_W'(i);
            if (count_r > CNT_W'(i)) begin
                out_valid[i]                    = 1'b1;
                out_instr[i*INSTR_W +: INSTR_W] = instr_mem_r[rd_idx_s];
                out_pc[i*ADDR_W +: ADDR_W]      = pc_mem_r[rd_idx_s];
            end else begin
                out_valid[i] = 1'b0;
            end
        end
    end

    assign imem_req_valid = req_s;
    assign imem_req_addr  = fetch_pc_r;
    assign queue_count    = count_r;

    // Fetch PC, in-flight tracking and queue pointers; redirect overrides all
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_r      <= ADDR_W'(RESET_PC);
            inflight_r      <= 1'b0;
            inflight_addr_r <= {ADDR_W{1'b0}};
            head_r          <= {PTR_W{1'b0}};
            tail_r          <= {PTR_W{1'b0}};
            count_r         <= {CNT_W{1'b0}};
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_pc;
            inflight_r <= 1'b0;
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
        end else begin
            if (req_s) begin
                fetch_pc_r      <= fetch_pc_r + ADDR_W'(FETCH_W);
                inflight_r      <= 1'b1;
                inflight_addr_r <= fetch_pc_r;
            end else begin
                inflight_r <= 1'b0;
            end
            if (inflight_r) begin
                tail_r <= tail_r + PTR_W'(FETCH_W);
            end
            head_r  <= head_r + PTR_W'(pop_s);
            count_r <= count_r - pop_s + push_s;
        end
    end

    // Queue storage: write the returning fetch group at the tail
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                instr_mem_r[i] <= {INSTR_W{1'b0}};
                pc_mem_r[i]    <= {ADDR_W{1'b0}};
            end
        end else if (!redirect_valid && inflight_r) begin
            for (int i = 0; i < FETCH_W; i++) begin
                instr_mem_r[tail_r + PTR_W'(i)] <= imem_rsp_data[i*INSTR_W +: INSTR_W];
                pc_mem_r[tail_r + PTR_W'(i)]    <= inflight_addr_r + ADDR_W'(i);
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed vector table, corner-case sequences and
// random traffic checked against a queue-based reference model.
module tb_fetch_queue_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_req_valid;
    logic [15:0] imem_req_addr;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        stall;
    logic [1:0]  deq_count;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [1:0]  out_valid;
    logic [3:0]  queue_count;

    int total = 0;
    int bad   = 0;

    fetch_queue_unit dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall), .deq_count(deq_count),
        .out_instr(out_instr), .out_pc(out_pc), .out_valid(out_valid),
        .queue_count(queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Synchronous instruction memory: data for the latched address one cycle later
    logic [15:0] mem_addr = 16'h0000;
    always @(posedge clk) if (imem_req_valid) mem_addr <= imem_req_addr;
    assign imem_rsp_data = {mem_word(mem_addr + 16'd1), mem_word(mem_addr)};

    // Reference model state
    logic [15:0] mq_pc[$];
    logic [15:0] m_fetch_pc;
    bit          m_inf;
    logic [15:0] m_inf_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_req();
        int sz = mq_pc.size();
        return reset_n && !redirect_valid && ((8 - sz) >= 2 * (1 + int'(m_inf)));
    endfunction

    task automatic model_reset();
        mq_pc.delete();
        m_fetch_pc = 16'h0000;
        m_inf      = 1'b0;
        m_inf_addr = 16'h0000;
    endtask

    task automatic model_check();
        logic [1:0]  ev;
        logic [31:0] ei;
        logic [31:0] ep;
        ev = 2'b00; ei = 32'h0; ep = 32'h0;
        for (int i = 0; i < 2; i++) begin
            if (i < mq_pc.size()) begin
                ev[i] = 1'b1;
                ep[i*16 +: 16] = mq_pc[i];
                ei[i*16 +: 16] = mem_word(mq_pc[i]);
            end
        end
        check("m_req_valid", imem_req_valid, model_req());
        check("m_req_addr", imem_req_addr, m_fetch_pc);
        check("m_count", queue_count, mq_pc.size());
        check("m_out_valid", out_valid, ev);
        check("m_out_pc", out_pc, ep);
        check("m_out_instr", out_instr, ei);
        check("count_bound", queue_count <= 4'd8, 1'b1);
    endtask

    task automatic model_step();
        bit req;
        int pop;
        req = model_req();
        if (redirect_valid) begin
            mq_pc.delete();
            m_inf      = 1'b0;
            m_fetch_pc = redirect_pc;
        end else begin
            pop = stall ? 0 : ((int'(deq_count) < mq_pc.size()) ? int'(deq_count) : mq_pc.size());
            repeat (pop) void'(mq_pc.pop_front());
            if (m_inf) begin
                mq_pc.push_back(m_inf_addr);
                mq_pc.push_back(m_inf_addr + 16'd1);
            end
            if (req) begin
                m_inf_addr = m_fetch_pc;
                m_fetch_pc = m_fetch_pc + 16'd2;
                m_inf      = 1'b1;
            end else begin
                m_inf = 1'b0;
            end
        end
    endtask

    task automatic drive(input bit st, input logic [1:0] dq, input bit rv, input logic [15:0] rpc);
        stall = st; deq_count = dq; redirect_valid = rv; redirect_pc = rpc;
        #1;
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_count", queue_count, 4'd0);
        check("rst_out_valid", out_valid, 2'b00);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit          rst;
        bit          st;
        logic [1:0]  dq;
        bit          e_req;
        logic [15:0] e_addr;
        int          e_cnt;
        logic [1:0]  e_ov;
        logic [15:0] e_p0;
        logic [15:0] e_p1;
    } vec_t;

    function automatic vec_t mk(bit rst, bit st, logic [1:0] dq, bit er, logic [15:0] ea,
                                int ec, logic [1:0] eov, logic [15:0] p0, logic [15:0] p1);
        vec_t v;
        v.rst = rst; v.st = st; v.dq = dq; v.e_req = er; v.e_addr = ea;
        v.e_cnt = ec; v.e_ov = eov; v.e_p0 = p0; v.e_p1 = p1;
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        reset_n = 1'b0; stall = 1'b0; deq_count = 2'd0;
        redirect_valid = 1'b0; redirect_pc = 16'h0000;
        model_reset();

        // Startup with full draining, then fill under stall and release
        tbl[0]  = mk(1, 0, 2, 1, 16'd0,  0, 2'b00, 16'd0, 16'd0);
        tbl[1]  = mk(0, 0, 2, 1, 16'd2,  0, 2'b00, 16'd0, 16'd0);
        tbl[2]  = mk(0, 0, 2, 1, 16'd4,  2, 2'b11, 16'd0, 16'd1);
        tbl[3]  = mk(0, 0, 2, 1, 16'd6,  2, 2'b11, 16'd2, 16'd3);
        tbl[4]  = mk(0, 0, 2, 1, 16'd8,  2, 2'b11, 16'd4, 16'd5);
        tbl[5]  = mk(0, 0, 2, 1, 16'd10, 2, 2'b11, 16'd6, 16'd7);
        tbl[6]  = mk(1, 1, 2, 1, 16'd0,  0, 2'b00, 16'd0, 16'd0);
        tbl[7]  = mk(0, 1, 2, 1, 16'd2,  0, 2'b00, 16'd0, 16'd0);
        tbl[8]  = mk(0, 1, 2, 1, 16'd4,  2, 2'b11, 16'd0, 16'd1);
        tbl[9]  = mk(0, 1, 2, 1, 16'd6,  4, 2'b11, 16'd0, 16'd1);
        tbl[10] = mk(0, 1, 2, 0, 16'd8,  6, 2'b11, 16'd0, 16'd1);
        tbl[11] = mk(0, 1, 2, 0, 16'd8,  8, 2'b11, 16'd0, 16'd1);
        tbl[12] = mk(0, 1, 2, 0, 16'd8,  8, 2'b11, 16'd0, 16'd1);
        tbl[13] = mk(0, 0, 2, 0, 16'd8,  8, 2'b11, 16'd0, 16'd1);
        tbl[14] = mk(0, 0, 2, 1, 16'd8,  6, 2'b11, 16'd2, 16'd3);
        tbl[15] = mk(0, 0, 2, 1, 16'd10, 4, 2'b11, 16'd4, 16'd5);
        tbl[16] = mk(0, 0, 2, 1, 16'd12, 4, 2'b11, 16'd6, 16'd7);
        tbl[17] = mk(0, 0, 2, 1, 16'd14, 4, 2'b11, 16'd8, 16'd9);

        @(negedge clk);
        for (int r = 0; r < 18; r++) begin
            logic [31:0] ei;
            if (tbl[r].rst) do_reset();
            drive(tbl[r].st, tbl[r].dq, 1'b0, 16'h0000);
            ei = 32'h0;
            if (tbl[r].e_ov[0]) ei[15:0]  = mem_word(tbl[r].e_p0);
            if (tbl[r].e_ov[1]) ei[31:16] = mem_word(tbl[r].e_p1);
            check("tbl_req_valid", imem_req_valid, tbl[r].e_req);
            check("tbl_req_addr", imem_req_addr, tbl[r].e_addr);
            check("tbl_count", queue_count, tbl[r].e_cnt);
            check("tbl_out_valid", out_valid, tbl[r].e_ov);
            check("tbl_out_pc", out_pc, {tbl[r].e_p1, tbl[r].e_p0});
            check("tbl_out_instr", out_instr, ei);
            advance();
        end

        // Redirect one cycle after the request to 0x0006
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(0, 2, 0, 16'h0000); model_check(); advance();
        end
        drive(0, 2, 1, 16'h0040);
        check("redir_no_req", imem_req_valid, 1'b0);
        model_check(); advance();
        drive(0, 2, 0, 16'h0000);
        check("redir_flushed", queue_count, 4'd0);
        check("redir_req_addr", {imem_req_valid, imem_req_addr}, {1'b1, 16'h0040});
        model_check(); advance();
        drive(0, 2, 0, 16'h0000);
        check("redir_req_addr2", imem_req_addr, 16'h0042);
        model_check(); advance();
        drive(0, 2, 0, 16'h0000);
        check("redir_first_pc", out_pc[15:0], 16'h0040);
        check("redir_first_valid", out_valid, 2'b11);
        model_check(); advance();

        // Redirect together with dequeue and an arriving response
        drive(0, 2, 1, 16'h0100);
        check("simul_no_req", imem_req_valid, 1'b0);
        model_check(); advance();
        drive(0, 2, 0, 16'h0000);
        check("simul_count", queue_count, 4'd0);
        check("simul_valid", out_valid, 2'b00);
        check("simul_req_addr", imem_req_addr, 16'h0100);
        model_check(); advance();

        // Dequeue request larger than the occupancy is clipped
        drive(0, 2, 0, 16'h0000);
        check("clip_valid", out_valid, 2'b00);
        check("clip_pc", out_pc, 32'h0);
        check("clip_instr", out_instr, 32'h0);
        model_check(); advance();
        drive(0, 2, 0, 16'h0000);
        check("clip_no_underflow", queue_count, 4'd2);
        model_check(); advance();

        // PC wrap around 0xFFFF
        drive(0, 2, 1, 16'hFFFE); model_check(); advance();
        drive(0, 2, 0, 16'h0000);
        check("wrap_req1", {imem_req_valid, imem_req_addr}, {1'b1, 16'hFFFE});
        model_check(); advance();
        drive(0, 2, 0, 16'h0000);
        check("wrap_req2", {imem_req_valid, imem_req_addr}, {1'b1, 16'h0000});
        model_check(); advance();
        drive(0, 2, 0, 16'h0000);
        check("wrap_pcs_a", out_pc, {16'hFFFF, 16'hFFFE});
        model_check(); advance();
        drive(0, 2, 0, 16'h0000);
        check("wrap_pcs_b", out_pc, {16'h0001, 16'h0000});
        model_check(); advance();

        // Asynchronous reset while the queue holds entries
        #2;
        do_reset();

        // Random traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            drive(($urandom % 4) == 0, 2'($urandom % 3), ($urandom % 20) == 0, 16'($urandom));
            model_check();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
